// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with per-slot blanking guard and frame snapshot.
// Optional macro BRIGHTNESS_EN adds a bright[3:0] input that shortens each digit's lit window.
module seg_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1_000,
    parameter int GUARD      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
`ifdef BRIGHTNESS_EN
    input  logic [3:0]  bright,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int SLOT = CLK_HZ / REFRESH_HZ;
    localparam int CW   = $clog2(SLOT);
    localparam logic [CW-1:0] SLOT_MAX = CW'(SLOT - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0][6:0] snap_digits;
    logic [3:0]      snap_dp;
    logic [3:0]      snap_blank;
    logic            frame_start;
    logic            lit_p0;

`ifdef BRIGHTNESS_EN
    localparam int OW = CW + 5;
    localparam logic [OW-1:0] ON_UNIT = OW'((SLOT - GUARD) >> 4);
    localparam logic [OW-1:0] GUARD_W = OW'(GUARD);

    logic [3:0]    snap_bright;
    logic [OW-1:0] on_len;
    logic          in_win;

    always_comb begin
        on_len = ON_UNIT * (OW'(snap_bright) + OW'(1));
        in_win = OW'(cnt) < (GUARD_W + on_len);
    end
`endif

    always_comb begin
        frame_start = (idx == 2'd0) && (cnt == '0);
        lit_p0      = (cnt >= GUARD_C) && !snap_blank[idx];
`ifdef BRIGHTNESS_EN
        lit_p0      = lit_p0 && in_win;
`endif
    end

    // scan counters, frame snapshot and registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 2'd0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            snap_digits <= '1;
            snap_dp     <= 4'b0000;
            snap_blank  <= 4'b1111;
`ifdef BRIGHTNESS_EN
            snap_bright <= 4'hF;
`endif
        end else begin
            if (cnt == SLOT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // New inputs are only taken at frame start; the guard keeps them off the pins until cnt==GUARD
            if (frame_start) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_blank  <= blank;
`ifdef BRIGHTNESS_EN
                snap_bright <= bright;
`endif
            end

            if (lit_p0) begin
                an  <= ~(4'b0001 << idx);
                seg <= snap_digits[idx];
                dp  <= ~snap_dp[idx];
            end else begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SLOT=34, GUARD=2; edge n is the n-th posedge after rst falls.
module tb_seg_scan_driver;

    localparam int CLK_HZ     = 3400;
    localparam int REFRESH_HZ = 100;
    localparam int GUARD      = 2;
    localparam logic [27:0] PAT = {7'b0010000, 7'b0000000, 7'b1111000, 7'b1000000};
    localparam logic [11:0] BLANK_OUT = {4'b1111, 7'b1111111, 1'b1};
    localparam logic [11:0] D0 = {4'b1110, 7'b1000000, 1'b1};
    localparam logic [11:0] D1 = {4'b1101, 7'b1111000, 1'b1};
    localparam logic [11:0] D2 = {4'b1011, 7'b0000000, 1'b1};
    localparam logic [11:0] D3 = {4'b0111, 7'b0010000, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] digits = '0;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blank = 4'b0000;
`ifdef BRIGHTNESS_EN
    logic [3:0]  bright = 4'hF;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    seg_scan_driver #(
        .CLK_HZ(CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ),
        .GUARD(GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digits(digits),
        .dp_in(dp_in),
        .blank(blank),
`ifdef BRIGHTNESS_EN
        .bright(bright),
`endif
        .seg(seg),
        .dp(dp),
        .an(an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        edge_n = -1;
    endtask

    task automatic test_reset();
        digits = PAT;
        dp_in  = 4'b0000;
        blank  = 4'b0000;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg, dp} !== BLANK_OUT) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got an=%b seg=%b dp=%b want %b", i, an, seg, dp, BLANK_OUT);
            end
        end
        rst = 1'b0;
        edge_n = -1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({an, seg, dp} !== BLANK_OUT) begin
                failures++;
                $display("FAIL reset_release edge %0d: got an=%b seg=%b dp=%b want %b", edge_n, an, seg, dp, BLANK_OUT);
            end
        end
    endtask

    task automatic test_normal_scan();
        logic [11:0] want;
        digits = PAT;
        dp_in  = 4'b0000;
        blank  = 4'b0000;
        do_reset();
        for (int e = 0; e < 140; e++) begin
            tick();
            want = BLANK_OUT;
            if (e >= 2 && e <= 33)        want = D0;
            else if (e >= 36 && e <= 67)  want = D1;
            else if (e >= 70 && e <= 101) want = D2;
            else if (e >= 104 && e <= 135) want = D3;
            else if (e >= 138)            want = D0;
            checks++;
            if ({an, seg, dp} !== want) begin
                failures++;
                $display("FAIL normal_scan edge %0d: got an=%b seg=%b dp=%b want %b", edge_n, an, seg, dp, want);
            end
        end
    endtask

    task automatic test_tear_free();
        logic [11:0] want;
        digits = PAT;
        dp_in  = 4'b0000;
        blank  = 4'b0000;
        do_reset();
        for (int e = 0; e < 140; e++) begin
            tick();
            if (edge_n == 20) digits[6:0] = 7'b1111001;
            want = BLANK_OUT;
            if (e >= 2 && e <= 33) want = D0;
            else if (e >= 138)      want = {4'b1110, 7'b1111001, 1'b1};
            if ((e >= 2 && e <= 33) || e >= 136) begin
                checks++;
                if ({an, seg, dp} !== want) begin
                    failures++;
                    $display("FAIL tear_free edge %0d: got an=%b seg=%b dp=%b want %b", edge_n, an, seg, dp, want);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [11:0] want;
        digits = PAT;
        dp_in  = 4'b0010;
        blank  = 4'b0100;
        do_reset();
        for (int e = 0; e < 140; e++) begin
            tick();
            want = BLANK_OUT;
            if (e >= 2 && e <= 33)          want = D0;
            else if (e >= 36 && e <= 67)    want = {4'b1101, 7'b1111000, 1'b0};
            else if (e >= 104 && e <= 135)  want = D3;
            else if (e >= 138)              want = D0;
            checks++;
            if ({an, seg, dp} !== want) begin
                failures++;
                $display("FAIL blank edge %0d: got an=%b seg=%b dp=%b want %b", edge_n, an, seg, dp, want);
            end
        end
        dp_in = 4'b0000;
        blank = 4'b0000;
    endtask

    task automatic test_reset_mid_scan();
        digits = PAT;
        do_reset();
        while (edge_n < 80) tick();
        checks++;
        if ({an, seg, dp} !== D2) begin
            failures++;
            $display("FAIL mid_before edge 80: got an=%b seg=%b dp=%b want %b", an, seg, dp, D2);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({an, seg, dp} !== BLANK_OUT) begin
            failures++;
            $display("FAIL mid_reset_blank: got an=%b seg=%b dp=%b want %b", an, seg, dp, BLANK_OUT);
        end
        tick();
        rst = 1'b0;
        edge_n = -1;
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if ({an, seg, dp} !== ((e >= 2) ? D0 : BLANK_OUT)) begin
                failures++;
                $display("FAIL mid_restart edge %0d: got an=%b seg=%b dp=%b want %b", edge_n, an, seg, dp,
                         (e >= 2) ? D0 : BLANK_OUT);
            end
        end
    endtask

`ifdef BRIGHTNESS_EN
    task automatic test_brightness();
        logic [3:0] want_an;
        digits = PAT;
        bright = 4'd7;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            tick();
            want_an = (e >= 2 && e <= 17) ? 4'b1110 : ((e >= 36) ? 4'b1101 : 4'b1111);
            checks++;
            if (an !== want_an) begin
                failures++;
                $display("FAIL brightness edge %0d: got an=%b want %b", edge_n, an, want_an);
            end
        end
        bright = 4'hF;
    endtask
`endif

    initial begin
        test_reset();
        test_normal_scan();
        test_tear_free();
        test_blank();
        test_reset_mid_scan();
`ifdef BRIGHTNESS_EN
        test_brightness();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
